bcd7seg_scan: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display fed with packed BCD.

---
 rtl/bcd7seg_scan_pkg.sv | 16 +
 rtl/bcd7seg_dec.sv | 33 +++
 rtl/bcd7seg_scan.sv | 153 +++++++++++++++
 tb/tb_bcd7seg_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd7seg_scan_pkg.sv
// Shared constants for the BCD 7-segment scanner: active-low segment codes {g,f,e,d,c,b,a}
// and the position of the decimal-point bit in the 8-bit segment bus.
package bcd7seg_scan_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         DP_BIT    = 7;
endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD digit + decimal point to active-low {dp,g,f,e,d,c,b,a}.
// Codes 10..15 leave all segments dark while the decimal point still follows dp.
module bcd7seg_dec
    import bcd7seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [6:0] segs_s;

    // BCD lookup, invalid codes dark
    always_comb begin
        segs_s = SEG_BLANK;
        case (bcd)
            4'd0:    segs_s = SEG_0;
            4'd1:    segs_s = SEG_1;
            4'd2:    segs_s = SEG_2;
            4'd3:    segs_s = SEG_3;
            4'd4:    segs_s = SEG_4;
            4'd5:    segs_s = SEG_5;
            4'd6:    segs_s = SEG_6;
            4'd7:    segs_s = SEG_7;
            4'd8:    segs_s = SEG_8;
            4'd9:    segs_s = SEG_9;
            default: segs_s = SEG_BLANK;
        endcase
        seg         = {1'b1, segs_s};
        seg[DP_BIT] = ~dp;
    end

endmodule

// File: rtl/bcd7seg_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining BCD7SEG_LZB_EN.
module bcd7seg_scan
    import bcd7seg_scan_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int GUARD    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    output logic [7:0]              sseg_out,
    output logic [N_DIGITS-1:0]     digit_enable,
    output logic                    frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [PW-1:0]                pre_r;
    logic [IW-1:0]                idx_r;
    logic [N_DIGITS-1:0][3:0]     pend_bcd_r;
    logic [N_DIGITS-1:0]          pend_dp_r;
    logic                         pend_valid_r;
    logic [N_DIGITS-1:0][3:0]     shad_bcd_r;
    logic [N_DIGITS-1:0]          shad_dp_r;
    logic [7:0]                   seg_r;
    logic [N_DIGITS-1:0]          en_r;
    logic                         fs_r;

    logic                         tick_s;
    logic                         boundary_s;
    logic                         guard_s;
    logic [N_DIGITS-1:0]          blank_s;
    logic [7:0]                   dec_seg_s;
    logic [7:0]                   seg_s;
    logic [N_DIGITS-1:0]          en_s;

    assign tick_s     = (pre_r == PRE_MAX);
    assign boundary_s = tick_s && (idx_r == IDX_MAX);

    // Prescaler and slot index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_r <= '0;
            idx_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
            idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + IW'(1);
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Pending/shadow buffers; a load on the boundary itself bypasses pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_bcd_r   <= '0;
            pend_dp_r    <= '0;
            pend_valid_r <= 1'b0;
            shad_bcd_r   <= '0;
            shad_dp_r    <= '0;
        end else if (boundary_s) begin
            pend_valid_r <= 1'b0;
            if (load) begin
                shad_bcd_r <= bcd_in;
                shad_dp_r  <= dp_in;
            end else if (pend_valid_r) begin
                shad_bcd_r <= pend_bcd_r;
                shad_dp_r  <= pend_dp_r;
            end else begin
                shad_bcd_r <= shad_bcd_r;
                shad_dp_r  <= shad_dp_r;
            end
        end else if (load) begin
            pend_bcd_r   <= bcd_in;
            pend_dp_r    <= dp_in;
            pend_valid_r <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    generate
        if (GUARD > 0) begin : g_guard
            assign guard_s = (pre_r < PW'(GUARD));
        end else begin : g_no_guard
            assign guard_s = 1'b0;
        end
    endgenerate

`ifdef BCD7SEG_LZB_EN
    logic lead_s;

    // A digit is a leading zero while it and everything above it is 0 with no dp
    always_comb begin
        lead_s  = 1'b1;
        blank_s = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            lead_s     = lead_s & (shad_bcd_r[k] == 4'd0) & ~shad_dp_r[k];
            blank_s[k] = lead_s;
        end
    end
`else
    assign blank_s = '0;
`endif

    bcd7seg_dec u_dec (
        .bcd (shad_bcd_r[idx_r]),
        .dp  (shad_dp_r[idx_r]),
        .seg (dec_seg_s)
    );

    // Next output values from the current slot state
    always_comb begin
        seg_s = 8'hFF;
        en_s  = '1;
        if (guard_s) begin
            seg_s = 8'hFF;
            en_s  = '1;
        end else begin
            en_s[idx_r] = 1'b0;
            if (blank_s[idx_r]) begin
                seg_s = 8'hFF;
            end else begin
                seg_s = dec_seg_s;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r <= 8'hFF;
            en_r  <= '1;
            fs_r  <= 1'b0;
        end else begin
            seg_r <= seg_s;
            en_r  <= en_s;
            fs_r  <= boundary_s;
        end
    end

    assign sseg_out     = seg_r;
    assign digit_enable = en_r;
    assign frame_start  = fs_r;

endmodule

// File: tb/tb_bcd7seg_scan.sv
// Self-checking bench for bcd7seg_scan (N_DIGITS=4, DIV=4, GUARD=1) against a cycle-count based model.
module tb_bcd7seg_scan;

    localparam int N  = 4;
    localparam int DV = 4;
    localparam int GD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic [7:0]  sseg_out;
    logic [3:0]  digit_enable;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    bcd7seg_scan #(.N_DIGITS(N), .DIV(DV), .GUARD(GD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bcd_in       (bcd_in),
        .dp_in        (dp_in),
        .load         (load),
        .sseg_out     (sseg_out),
        .digit_enable (digit_enable),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: slot position derived from cycles elapsed since reset
    int          t = 0;
    bit          started = 0;
    logic [15:0] sh_b = 16'h0, pe_b = 16'h0;
    logic [3:0]  sh_dp = 4'h0, pe_dp = 4'h0;
    bit          pv = 0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_en = 4'hF;
    bit          exp_fs = 0;
    logic [7:0]  tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] model_seg(int k);
        int  d;
        bit  dp, lead;
        logic [7:0] s;
        d  = int'(sh_b[4*k +: 4]);
        dp = sh_dp[k];
        s  = (d < 10) ? tbl[d] : 8'hFF;
        if (dp) s[7] = 1'b0;
`ifdef BCD7SEG_LZB_EN
        lead = (k > 0);
        for (int j = k; j < N; j++)
            if (sh_b[4*j +: 4] != 4'd0 || sh_dp[j]) lead = 0;
        if (lead) s = 8'hFF;
`else
        lead = 0;
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        int p, k;
        bit bnd;
        started = 1;
        if (!rst_n) begin
            t = 0; sh_b = 0; sh_dp = 0; pe_b = 0; pe_dp = 0; pv = 0;
            exp_seg = 8'hFF; exp_en = 4'hF; exp_fs = 0;
        end else begin
            p = t % DV;
            k = (t / DV) % N;
            if (p < GD) begin
                exp_seg = 8'hFF; exp_en = 4'hF;
            end else begin
                exp_en  = 4'hF & ~(4'h1 << k);
                exp_seg = model_seg(k);
            end
            bnd    = (p == DV - 1) && (k == N - 1);
            exp_fs = bnd;
            if (bnd) begin
                if (load) begin sh_b = bcd_in; sh_dp = dp_in; end
                else if (pv) begin sh_b = pe_b; sh_dp = pe_dp; end
                pv = 0;
            end else if (load) begin
                pe_b = bcd_in; pe_dp = dp_in; pv = 1;
            end
            t++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("sseg_out", 32'(sseg_out), 32'(exp_seg));
            chk("digit_enable", 32'(digit_enable), 32'(exp_en));
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic wait_fs();
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (frame_start) hit = 1;
        end
        if (!hit) chk("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Wait for a given anode pattern, then pin both DUT and model to a literal
    task automatic check_digit(input string name, input logic [3:0] en, input logic [7:0] seg);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (digit_enable == en) hit = 1;
        end
        if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk(name, 32'(sseg_out), 32'(seg));
            chk({name, "_model"}, 32'(exp_seg), 32'(seg));
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        bcd_in = b; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0; bcd_in = $urandom; dp_in = 4'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(sseg_out), 32'hFF);
        chk("reset_en", 32'(digit_enable), 32'hF);
        chk("reset_fs", 32'(frame_start), 32'h0);
        rst_n = 1'b1;

        do_load(16'h1234, 4'h0);
        wait_fs();
        check_digit("d0_4", 4'hE, 8'h99);
        check_digit("d1_3", 4'hD, 8'hB0);
        check_digit("d2_2", 4'hB, 8'hA4);
        check_digit("d3_1", 4'h7, 8'hF9);

        wait_fs();
        repeat (2) @(negedge clk);
        do_load(16'h5678, 4'h0);
        repeat (3) @(negedge clk);
        do_load(16'h9012, 4'h0);
        check_digit("old_d2", 4'hB, 8'hA4);
        wait_fs();
        check_digit("new_d0", 4'hE, 8'hA4);
        check_digit("new_d3", 4'h7, 8'h90);

        do_load(16'h00A0, 4'b0010);
        wait_fs();
        check_digit("a_d0", 4'hE, 8'hC0);
        check_digit("a_d1", 4'hD, 8'h7F);
`ifdef BCD7SEG_LZB_EN
        check_digit("a_d2", 4'hB, 8'hFF);
`else
        check_digit("a_d2", 4'hB, 8'hC0);
`endif

        do_load(16'h0007, 4'h0);
        wait_fs();
        check_digit("z_d0", 4'hE, 8'hF8);
`ifdef BCD7SEG_LZB_EN
        check_digit("z_d3", 4'h7, 8'hFF);
`else
        check_digit("z_d3", 4'h7, 8'hC0);
`endif

        do_load(16'h4321, 4'h0);
        check_digit("pre_rst", 4'hB, 8'hB0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", 32'(sseg_out), 32'hFF);
        chk("midrst_en", 32'(digit_enable), 32'hF);
        rst_n = 1'b1;
        check_digit("post_rst_d0", 4'hE, 8'hC0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 149) != 0);
            load  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       bcd_in = 16'($urandom);
                1:       bcd_in = 16'($urandom_range(0, 9));
                default: bcd_in = {4'd0, 4'($urandom_range(0, 9)), 4'd0, 4'($urandom_range(0, 15))};
            endcase
            dp_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
